// File: rtl/led_chain_frame_sequencer_if.sv
// Bus between the LED chain frame sequencer and its pixel data source / encoder.
//
// Handshake: the sequencer (master) presents pixel_addr, held stable for the
// whole FETCH state. The source (slave) raises pixel_ready once it has channel
// values for that address. A transfer happens on the clock edge where the
// sequencer is in FETCH and pixel_ready=1. pixel_ready is ignored in all other
// states. The source may hold pixel_ready low for any number of cycles, and the
// sequencer waits without a timeout.
`timescale 1ns/1ps
interface led_chain_frame_sequencer_if #(
  parameter int PIX_W   = 6,
  parameter int FRAME_W = 5
);
  logic               enable;
  logic               pixel_ready;
  logic               load_sreg;
  logic               transmit_pixel;
  logic [PIX_W-1:0]   pixel_addr;
  logic [FRAME_W-1:0] frame;
  logic               frame_done;
  logic               busy;
  logic [2:0]         fsm_state;  // debug view of the sequencer FSM

  modport master (
    input  enable, pixel_ready,
    output load_sreg, transmit_pixel, pixel_addr, frame, frame_done, busy, fsm_state
  );

  modport slave (
    output enable, pixel_ready,
    input  load_sreg, transmit_pixel, pixel_addr, frame, frame_done, busy, fsm_state
  );
endinterface

// File: rtl/led_chain_frame_sequencer.sv
// Frame sequencer for a serial RGB LED chain (WS2812-class).
// For each of NUM_PIXELS pixels, it fetches the pixel data, pulses a shift-register
// load, and then holds transmit for one pixel time. After the last pixel it holds
// the line idle for the latch gap and advances the frame counter.
// All flops update on the falling clock edge. Reset is asynchronous and active low.
// Optional build macro LEDCTRL_SERPENTINE_EN: maps the chain index to a serpentine
// matrix address on pixel_addr.
`timescale 1ns/1ps
module led_chain_frame_sequencer #(
  parameter int NUM_PIXELS     = 64,
  parameter int BITS_PER_PIXEL = 24,
  parameter int CYCLES_PER_BIT = 15,
  parameter int IDLE_CYCLES    = 3518320,
  parameter int FRAME_W        = 5,
  parameter int MATRIX_WIDTH   = 8
) (
  input  logic clk,
  input  logic rst_n,
  led_chain_frame_sequencer_if.master bus
);

  localparam int PIX_W        = $clog2(NUM_PIXELS);
  localparam int SHIFT_CYCLES = BITS_PER_PIXEL * CYCLES_PER_BIT;
  localparam int MAX_COUNT    = (SHIFT_CYCLES > IDLE_CYCLES) ? SHIFT_CYCLES : IDLE_CYCLES;
  localparam int CNT_W        = $clog2(MAX_COUNT + 1);

  // Reject configurations the sequencer cannot serve.
  if (NUM_PIXELS < 2) begin : g_bad_num_pixels
    $error("NUM_PIXELS must be at least 2");
  end
  if (IDLE_CYCLES < 1) begin : g_bad_idle
    $error("IDLE_CYCLES must be at least 1");
  end
  if ((MATRIX_WIDTH < 1) || ((NUM_PIXELS % MATRIX_WIDTH) != 0)) begin : g_bad_matrix
    $error("MATRIX_WIDTH must divide NUM_PIXELS");
  end

  typedef enum logic [2:0] {
    STOP  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    SHIFT = 3'd3,
    LATCH = 3'd4
  } state_t;

  state_t             state, state_next;
  logic [PIX_W-1:0]   idx, idx_next;
  logic [FRAME_W-1:0] frame_q, frame_next;
  logic [CNT_W-1:0]   cnt, cnt_next;  // shift-bit / latch-gap cycle counter
  logic               shift_last, idle_last, idx_last;
  logic [PIX_W-1:0]   addr_map;

  assign shift_last = (cnt == CNT_W'(SHIFT_CYCLES - 1));
  assign idle_last  = (cnt == CNT_W'(IDLE_CYCLES - 1));
  assign idx_last   = (idx == PIX_W'(NUM_PIXELS - 1));

  // State, chain index, frame and counter registers (falling edge, async reset).
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= STOP;
      idx     <= '0;
      frame_q <= '0;
      cnt     <= '0;
    end else begin
      state   <= state_next;
      idx     <= idx_next;
      frame_q <= frame_next;
      cnt     <= cnt_next;
    end
  end

  // Next-state logic. enable is only looked at in STOP and on the last latch cycle,
  // so a frame that has started always runs to the end of its latch gap.
  always_comb begin
    state_next = state;
    idx_next   = idx;
    frame_next = frame_q;
    cnt_next   = cnt;
    case (state)
      STOP: begin
        if (bus.enable) state_next = FETCH;
      end
      FETCH: begin
        if (bus.pixel_ready) state_next = LOAD;
      end
      LOAD: begin
        cnt_next   = '0;
        state_next = SHIFT;
      end
      SHIFT: begin
        if (shift_last) begin
          cnt_next = '0;
          if (idx_last) begin
            idx_next   = '0;
            state_next = LATCH;
          end else begin
            idx_next   = idx + PIX_W'(1);
            state_next = FETCH;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      LATCH: begin
        if (idle_last) begin
          cnt_next   = '0;
          frame_next = frame_q + FRAME_W'(1);
          state_next = bus.enable ? FETCH : STOP;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_next = STOP;
        cnt_next   = '0;
      end
    endcase
  end

`ifdef LEDCTRL_SERPENTINE_EN
  logic [31:0] idx_w, row_w, col_w;

  // Serpentine matrix: odd rows run right-to-left, so their column is mirrored.
  always_comb begin
    idx_w = 32'(idx);
    row_w = idx_w / 32'(MATRIX_WIDTH);
    col_w = idx_w % 32'(MATRIX_WIDTH);
    if (row_w[0]) begin
      addr_map = PIX_W'(row_w * 32'(MATRIX_WIDTH) + 32'(MATRIX_WIDTH - 1) - col_w);
    end else begin
      addr_map = idx;
    end
  end
`else
  // Chain order and address order coincide.
  always_comb begin
    addr_map = idx;
  end
`endif

  // Outputs are decoded from registered state only.
  assign bus.load_sreg      = (state == LOAD);
  assign bus.transmit_pixel = (state == SHIFT);
  assign bus.frame_done     = (state == LATCH) && idle_last;
  assign bus.busy           = (state != STOP);
  assign bus.pixel_addr     = addr_map;
  assign bus.frame          = frame_q;
  assign bus.fsm_state      = state;

endmodule

// File: tb/tb_led_chain_frame_sequencer.sv
// Directed bench for led_chain_frame_sequencer (NUM_PIXELS=4, 24 bits x 15 cycles,
// 100-cycle latch gap, 2-bit frame counter, MATRIX_WIDTH=2).
// The DUT is active on the falling edge. Stimulus is driven and outputs are sampled
// on the rising edge.
`timescale 1ns/1ps
module tb_led_chain_frame_sequencer;

  localparam int NP = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  led_chain_frame_sequencer_if #(.PIX_W(2), .FRAME_W(2)) bus ();

  led_chain_frame_sequencer #(
    .NUM_PIXELS(NP), .BITS_PER_PIXEL(24), .CYCLES_PER_BIT(15),
    .IDLE_CYCLES(100), .FRAME_W(2), .MATRIX_WIDTH(2)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

`ifdef LEDCTRL_SERPENTINE_EN
  int exp_addr[NP] = '{0, 1, 3, 2};
`else
  int exp_addr[NP] = '{0, 1, 2, 3};
`endif

  // Observations collected by observe()
  int load_cyc[$];
  int load_addr[$];
  int tx_len[$];
  int fd_cyc[$];
  int fd_frame[$];
  int stall_addrs[$];
  int frame_post;
  bit timed_out;

  task automatic do_reset();
    bus.enable = 1'b0;
    bus.pixel_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  // Steps cycle by cycle (cycle 0 = first posedge after the call) and records events.
  // The run stops `extra` cycles after frame_done number frames_target.
  task automatic observe(input int frames_target, input int extra, input int max_cycles,
                         input int stall_pix, input int stall_len, input int drop_pix);
    int c, cur_tx, stall_left, end_c, last_fd;
    load_cyc.delete(); load_addr.delete(); tx_len.delete();
    fd_cyc.delete(); fd_frame.delete(); stall_addrs.delete();
    c = 0; cur_tx = 0; stall_left = 0; end_c = -1; last_fd = -10;
    frame_post = -1; timed_out = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.pixel_ready == 1'b0) stall_addrs.push_back(int'(bus.pixel_addr));
      if (bus.load_sreg) begin
        load_cyc.push_back(c);
        load_addr.push_back(int'(bus.pixel_addr));
      end
      if (bus.transmit_pixel) begin
        cur_tx++;
        if (drop_pix >= 0 && load_cyc.size() == drop_pix + 1) bus.enable = 1'b0;
      end else if (cur_tx > 0) begin
        tx_len.push_back(cur_tx);
        cur_tx = 0;
      end
      if (c == last_fd + 1) frame_post = int'(bus.frame);
      if (bus.frame_done) begin
        fd_cyc.push_back(c);
        fd_frame.push_back(int'(bus.frame));
        last_fd = c;
        if (fd_cyc.size() == frames_target) end_c = c + extra;
      end
      if (stall_pix >= 0 && bus.transmit_pixel && cur_tx == 360 && load_cyc.size() == stall_pix)
        stall_left = stall_len + 1;
      if (stall_left > 0) begin
        bus.pixel_ready = 1'b0;
        stall_left--;
      end else begin
        bus.pixel_ready = 1'b1;
      end
      if (c == end_c) break;
      c++;
      if (c >= max_cycles) begin
        timed_out = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    bus.enable = 1'b0;
    bus.pixel_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    n_vec++; if (bus.load_sreg !== 1'b0) begin n_err++; $display("FAIL reset_load_sreg got %b want 0", bus.load_sreg); end
    n_vec++; if (bus.transmit_pixel !== 1'b0) begin n_err++; $display("FAIL reset_transmit got %b want 0", bus.transmit_pixel); end
    n_vec++; if (bus.pixel_addr !== 2'd0) begin n_err++; $display("FAIL reset_pixel_addr got %0d want 0", bus.pixel_addr); end
    n_vec++; if (bus.frame !== 2'd0) begin n_err++; $display("FAIL reset_frame got %0d want 0", bus.frame); end
    n_vec++; if (bus.frame_done !== 1'b0) begin n_err++; $display("FAIL reset_frame_done got %b want 0", bus.frame_done); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL idle_no_enable_busy got %b want 0", bus.busy); end
  endtask

  task automatic test_single_frame();
    do_reset();
    bus.enable = 1'b1;
    bus.pixel_ready = 1'b1;
    observe(1, 1, 10000, -1, 0, -1);
    n_vec++; if (timed_out) begin n_err++; $display("FAIL frame1_timeout got timeout want frame_done"); end
    n_vec++; if (load_cyc.size() != NP) begin n_err++; $display("FAIL frame1_load_count got %0d want %0d", load_cyc.size(), NP); end
    n_vec++; if (load_cyc.size() > 0 && load_cyc[0] != 1) begin n_err++; $display("FAIL frame1_first_load got %0d want 1", load_cyc[0]); end
    for (int i = 0; i < NP && i < load_cyc.size(); i++) begin
      n_vec++; if (load_addr[i] != exp_addr[i]) begin n_err++; $display("FAIL frame1_addr[%0d] got %0d want %0d", i, load_addr[i], exp_addr[i]); end
      if (i > 0) begin
        n_vec++; if (load_cyc[i] - load_cyc[i-1] != 362) begin n_err++; $display("FAIL frame1_load_period[%0d] got %0d want 362", i, load_cyc[i] - load_cyc[i-1]); end
      end
    end
    n_vec++; if (tx_len.size() != NP) begin n_err++; $display("FAIL frame1_tx_count got %0d want %0d", tx_len.size(), NP); end
    for (int i = 0; i < tx_len.size(); i++) begin
      n_vec++; if (tx_len[i] != 360) begin n_err++; $display("FAIL frame1_tx_len[%0d] got %0d want 360", i, tx_len[i]); end
    end
    n_vec++; if (fd_cyc.size() != 1 || fd_cyc[0] != 1547) begin n_err++; $display("FAIL frame1_done_cycle got %0d want 1547", (fd_cyc.size() > 0) ? fd_cyc[0] : -1); end
    n_vec++; if (fd_frame.size() != 1 || fd_frame[0] != 0) begin n_err++; $display("FAIL frame1_frame_at_done got %0d want 0", (fd_frame.size() > 0) ? fd_frame[0] : -1); end
    n_vec++; if (frame_post != 1) begin n_err++; $display("FAIL frame1_frame_after got %0d want 1", frame_post); end
  endtask

  task automatic test_ready_stall();
    do_reset();
    bus.enable = 1'b1;
    bus.pixel_ready = 1'b1;
    observe(1, 1, 10000, 2, 10, -1);
    n_vec++; if (timed_out) begin n_err++; $display("FAIL stall_timeout got timeout want frame_done"); end
    n_vec++; if (load_cyc.size() != NP) begin n_err++; $display("FAIL stall_load_count got %0d want %0d", load_cyc.size(), NP); end
    n_vec++; if (load_cyc.size() > 2 && load_cyc[2] != 735) begin n_err++; $display("FAIL stall_load2_cycle got %0d want 735", load_cyc[2]); end
    n_vec++; if (load_cyc.size() > 3 && load_cyc[3] != 1097) begin n_err++; $display("FAIL stall_load3_cycle got %0d want 1097", load_cyc[3]); end
    n_vec++; if (stall_addrs.size() != 11) begin n_err++; $display("FAIL stall_wait_cycles got %0d want 11", stall_addrs.size()); end
    for (int i = 0; i < stall_addrs.size(); i++) begin
      n_vec++; if (stall_addrs[i] != exp_addr[2]) begin n_err++; $display("FAIL stall_addr_hold[%0d] got %0d want %0d", i, stall_addrs[i], exp_addr[2]); end
    end
    for (int i = 0; i < tx_len.size(); i++) begin
      n_vec++; if (tx_len[i] != 360) begin n_err++; $display("FAIL stall_tx_len[%0d] got %0d want 360", i, tx_len[i]); end
    end
    n_vec++; if (fd_cyc.size() != 1 || fd_cyc[0] != 1557) begin n_err++; $display("FAIL stall_done_cycle got %0d want 1557", (fd_cyc.size() > 0) ? fd_cyc[0] : -1); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    bus.enable = 1'b1;
    bus.pixel_ready = 1'b1;
    observe(1, 50, 10000, -1, 0, 1);
    n_vec++; if (timed_out) begin n_err++; $display("FAIL drop_timeout got timeout want frame_done"); end
    n_vec++; if (load_cyc.size() != NP) begin n_err++; $display("FAIL drop_load_count got %0d want %0d", load_cyc.size(), NP); end
    n_vec++; if (fd_cyc.size() != 1 || fd_cyc[0] != 1547) begin n_err++; $display("FAIL drop_done_cycle got %0d want 1547", (fd_cyc.size() > 0) ? fd_cyc[0] : -1); end
    n_vec++; if (frame_post != 1) begin n_err++; $display("FAIL drop_frame_after got %0d want 1", frame_post); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL drop_busy_stopped got %b want 0", bus.busy); end
    n_vec++; if (bus.frame !== 2'd1) begin n_err++; $display("FAIL drop_frame_hold got %0d want 1", bus.frame); end
    bus.enable = 1'b1;
    observe(1, 1, 10000, -1, 0, -1);
    n_vec++; if (load_cyc.size() == 0 || load_cyc[0] != 1) begin n_err++; $display("FAIL restart_first_load got %0d want 1", (load_cyc.size() > 0) ? load_cyc[0] : -1); end
    n_vec++; if (load_addr.size() == 0 || load_addr[0] != exp_addr[0]) begin n_err++; $display("FAIL restart_addr got %0d want %0d", (load_addr.size() > 0) ? load_addr[0] : -1, exp_addr[0]); end
    n_vec++; if (fd_frame.size() != 1 || fd_frame[0] != 1) begin n_err++; $display("FAIL restart_frame got %0d want 1", (fd_frame.size() > 0) ? fd_frame[0] : -1); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.enable = 1'b1;
    bus.pixel_ready = 1'b1;
    repeat (400) @(posedge clk);
    n_vec++; if (bus.transmit_pixel !== 1'b1) begin n_err++; $display("FAIL midrst_pre_shift got %b want 1", bus.transmit_pixel); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (bus.transmit_pixel !== 1'b0) begin n_err++; $display("FAIL midrst_transmit got %b want 0", bus.transmit_pixel); end
    n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", bus.busy); end
    n_vec++; if (bus.pixel_addr !== 2'd0) begin n_err++; $display("FAIL midrst_addr got %0d want 0", bus.pixel_addr); end
    n_vec++; if (bus.load_sreg !== 1'b0 || bus.frame_done !== 1'b0 || bus.frame !== 2'd0) begin n_err++; $display("FAIL midrst_other got load=%b done=%b frame=%0d want 0 0 0", bus.load_sreg, bus.frame_done, bus.frame); end
    @(posedge clk);
    rst_n = 1'b1;
    observe(1, 1, 10000, -1, 0, -1);
    n_vec++; if (load_cyc.size() == 0 || load_cyc[0] != 1 || load_addr[0] != exp_addr[0]) begin n_err++; $display("FAIL midrst_restart got cyc=%0d addr=%0d want cyc=1 addr=%0d", (load_cyc.size() > 0) ? load_cyc[0] : -1, (load_addr.size() > 0) ? load_addr[0] : -1, exp_addr[0]); end
    n_vec++; if (fd_frame.size() != 1 || fd_frame[0] != 0) begin n_err++; $display("FAIL midrst_frame got %0d want 0", (fd_frame.size() > 0) ? fd_frame[0] : -1); end
  endtask

  task automatic test_back_to_back();
    int exp_fr[5] = '{0, 1, 2, 3, 0};
    do_reset();
    bus.enable = 1'b1;
    bus.pixel_ready = 1'b1;
    observe(5, 700, 20000, -1, 0, -1);
    n_vec++; if (timed_out) begin n_err++; $display("FAIL b2b_timeout got timeout want 5 frames"); end
    n_vec++; if (fd_cyc.size() != 5) begin n_err++; $display("FAIL b2b_done_count got %0d want 5", fd_cyc.size()); end
    for (int i = 0; i < fd_frame.size() && i < 5; i++) begin
      n_vec++; if (fd_frame[i] != exp_fr[i]) begin n_err++; $display("FAIL b2b_frame[%0d] got %0d want %0d", i, fd_frame[i], exp_fr[i]); end
      n_vec++; if (fd_cyc[i] != 1547 + 1548 * i) begin n_err++; $display("FAIL b2b_done_cycle[%0d] got %0d want %0d", i, fd_cyc[i], 1547 + 1548 * i); end
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_ready_stall();
    test_enable_drop();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
